// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state type and default sizes.
package shared_reg_arbiter_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Pointer width stays at least one bit so a 1-requester build still elaborates.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first high request found when scanning
// from the pointer upward and wrapping past N-1 back to 0.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = ptr_width(DEF_N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win_onehot,
  output logic [PW-1:0] o_win_idx,
  output logic          o_any
);

  logic [PW:0]   w_pos;
  logic [PW-1:0] w_idx;

  // Wrap uses an explicit compare against N so non-power-of-two N scans correctly.
  always_comb begin
    o_win_onehot = '0;
    o_win_idx    = '0;
    o_any        = 1'b0;
    w_pos        = '0;
    w_idx        = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_pos >= (PW+1)'(N)) begin
        w_pos = w_pos - (PW+1)'(N);
      end
      w_idx = w_pos[PW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any     = 1'b1;
        o_win_idx = w_idx;
      end
    end
    if (o_any) begin
      o_win_onehot[o_win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register bank
// with registered true/complement outputs.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] WDATA,
  input  logic           CLR,
  output logic [N-1:0]   GNT,
  output logic           ACK,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   QN,
  output logic           BUSY
);

  localparam int PW = ptr_width(N);

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gnt_idx;
  logic [PW-1:0] w_ptr_next;
  logic [PW-1:0] w_gnt_idx_next;
  logic [PW-1:0] w_win_idx;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  w_gnt_next;
  logic [N-1:0]  w_win_onehot;
  logic          r_ack;
  logic          w_ack_next;
  logic          w_any;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_qn;
  logic [W-1:0]  w_q_next;
  logic [W-1:0]  w_qn_next;
  logic [W-1:0]  w_wdata_sel;
  logic          w_granted_req;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req        (REQ),
    .i_ptr        (r_ptr),
    .o_win_onehot (w_win_onehot),
    .o_win_idx    (w_win_idx),
    .o_any        (w_any)
  );

  assign w_granted_req = REQ[r_gnt_idx];

  // Write-data mux keyed by the registered grant index, not the live picker.
  always_comb begin
    w_wdata_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt_idx == PW'(i)) begin
        w_wdata_sel = WDATA[i*W +: W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!CLR && w_any) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: w_next_state = w_granted_req ? ST_DONE : ST_IDLE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // A requester that drops REQ during WRITE aborts: no write, no ACK, pointer kept.
  always_comb begin
    w_gnt_next     = '0;
    w_gnt_idx_next = r_gnt_idx;
    w_ack_next     = 1'b0;
    w_ptr_next     = r_ptr;
    w_q_next       = r_q;
    w_qn_next      = r_qn;
    case (r_state)
      ST_IDLE: begin
        if (CLR) begin
          w_q_next  = '0;
          w_qn_next = '1;
        end else if (w_any) begin
          w_gnt_next     = w_win_onehot;
          w_gnt_idx_next = w_win_idx;
        end
      end
      ST_WRITE: begin
        if (w_granted_req) begin
          w_q_next   = w_wdata_sel;
          w_qn_next  = ~w_wdata_sel;
          w_ack_next = 1'b1;
          w_ptr_next = (r_gnt_idx == PW'(N-1)) ? '0 : r_gnt_idx + PW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ack     <= 1'b0;
      r_q       <= '0;
      r_qn      <= '1;
    end else begin
      r_ptr     <= w_ptr_next;
      r_gnt     <= w_gnt_next;
      r_gnt_idx <= w_gnt_idx_next;
      r_ack     <= w_ack_next;
      r_q       <= w_q_next;
      r_qn      <= w_qn_next;
    end
  end

  assign GNT  = r_gnt;
  assign ACK  = r_ack;
  assign Q    = r_q;
  assign QN   = r_qn;
  assign BUSY = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized transaction loop,
// all checked against a transaction-level model of pointer and stored value.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int OW = N + 2 + 2*W;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] WDATA;
  logic           CLR;
  logic [N-1:0]   GNT;
  logic           ACK;
  logic [W-1:0]   Q;
  logic [W-1:0]   QN;
  logic           BUSY;

  int             total = 0;
  int             bad   = 0;
  int             m_ptr = 0;
  logic [W-1:0]   m_q   = '0;
  logic [OW-1:0]  obs;
  logic [OW-1:0]  exp_v;

  assign obs = {GNT, ACK, BUSY, Q, QN};

  always #5 CLK = ~CLK;

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .WDATA (WDATA),
    .CLR   (CLR),
    .GNT   (GNT),
    .ACK   (ACK),
    .Q     (Q),
    .QN    (QN),
    .BUSY  (BUSY)
  );

  function automatic logic [OW-1:0] expect_out(logic [N-1:0] g, logic a, logic b, logic [W-1:0] q);
    return {g, a, b, q, ~q};
  endfunction

  function automatic int rr_winner(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_data(int i, logic [W-1:0] d);
    WDATA[i*W +: W] = d;
  endtask

  task automatic test_reset();
    int w;
    RST = 1'b1; REQ = '1; CLR = 1'b0; WDATA = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++; exp_v = expect_out('0, 1'b0, 1'b0, 8'h00);
      if (obs !== exp_v) begin bad++; $display("FAIL reset_hold%0d got=%h want=%h", c, obs, exp_v); end
    end
    m_ptr = 0; m_q = '0;
    RST = 1'b0; set_data(0, 8'h11);
    w = rr_winner(REQ, m_ptr);
    step();
    total++; exp_v = expect_out(4'b0001, 1'b0, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL reset_first_grant got=%h want=%h", obs, exp_v); end
    step();
    m_q = 8'h11; m_ptr = (w + 1) % N;
    total++; exp_v = expect_out('0, 1'b1, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL reset_first_ack got=%h want=%h", obs, exp_v); end
    REQ = '0;
    step();
    total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL reset_first_done got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_single_write();
    int w;
    REQ = 4'b0100; set_data(2, 8'hA5);
    w = rr_winner(REQ, m_ptr);
    step();
    total++; exp_v = expect_out(4'b0100, 1'b0, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL single_grant got=%h want=%h", obs, exp_v); end
    step();
    m_q = 8'hA5; m_ptr = (w + 1) % N;
    total++; exp_v = expect_out('0, 1'b1, 1'b1, 8'hA5);
    if (obs !== exp_v) begin bad++; $display("FAIL single_ack got=%h want=%h", obs, exp_v); end
    REQ = '0;
    step();
    total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL single_idle got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_round_robin();
    int w;
    RST = 1'b1; REQ = '0;
    step();
    RST = 1'b0; m_ptr = 0; m_q = '0;
    total++; exp_v = expect_out('0, 1'b0, 1'b0, 8'h00);
    if (obs !== exp_v) begin bad++; $display("FAIL rr_reset got=%h want=%h", obs, exp_v); end
    REQ = '1;
    for (int k = 0; k < 5; k++) begin
      WDATA = $urandom;
      w = rr_winner(REQ, m_ptr);
      step();
      total++; exp_v = expect_out(onehot(w), 1'b0, 1'b1, m_q);
      if (obs !== exp_v) begin bad++; $display("FAIL rr_grant%0d got=%h want=%h", k, obs, exp_v); end
      step();
      m_q = WDATA[w*W +: W]; m_ptr = (w + 1) % N;
      total++; exp_v = expect_out('0, 1'b1, 1'b1, m_q);
      if (obs !== exp_v) begin bad++; $display("FAIL rr_ack%0d got=%h want=%h", k, obs, exp_v); end
      REQ[w] = 1'b0;
      step();
      REQ = '1;
    end
    REQ = '0;
    step();
    total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL rr_settle got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_abort();
    int w;
    REQ = 4'b0010; set_data(1, 8'h77); set_data(0, 8'h99);
    w = rr_winner(REQ, m_ptr);
    step();
    total++; exp_v = expect_out(onehot(w), 1'b0, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL abort_grant got=%h want=%h", obs, exp_v); end
    REQ = '0;
    step();
    total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL abort_no_ack got=%h want=%h", obs, exp_v); end
    REQ = 4'b0011;
    w = rr_winner(REQ, m_ptr);
    step();
    total++; exp_v = expect_out(4'b0010, 1'b0, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL abort_regrant got=%h want=%h", obs, exp_v); end
    step();
    m_q = WDATA[w*W +: W]; m_ptr = (w + 1) % N;
    total++; exp_v = expect_out('0, 1'b1, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL abort_ack got=%h want=%h", obs, exp_v); end
    REQ = '0;
    step();
  endtask

  task automatic test_clr_priority();
    int w;
    REQ = 4'b1000; set_data(3, 8'h3C);
    w = rr_winner(REQ, m_ptr);
    step();
    step();
    m_q = 8'h3C; m_ptr = (w + 1) % N;
    total++; exp_v = expect_out('0, 1'b1, 1'b1, 8'h3C);
    if (obs !== exp_v) begin bad++; $display("FAIL clr_setup got=%h want=%h", obs, exp_v); end
    REQ = '0;
    step();
    CLR = 1'b1; REQ = 4'b0001; set_data(0, 8'h5E);
    step();
    m_q = '0;
    total++; exp_v = expect_out('0, 1'b0, 1'b0, 8'h00);
    if (obs !== exp_v) begin bad++; $display("FAIL clr_priority got=%h want=%h", obs, exp_v); end
    CLR = 1'b0;
    w = rr_winner(REQ, m_ptr);
    step();
    total++; exp_v = expect_out(4'b0001, 1'b0, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL clr_then_grant got=%h want=%h", obs, exp_v); end
    step();
    m_q = 8'h5E; m_ptr = (w + 1) % N;
    REQ = '0;
    step();
  endtask

  task automatic test_reset_mid_write();
    int w;
    REQ = 4'b0001; set_data(0, 8'hFF);
    w = rr_winner(REQ, m_ptr);
    step();
    total++; exp_v = expect_out(onehot(w), 1'b0, 1'b1, m_q);
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_grant got=%h want=%h", obs, exp_v); end
    RST = 1'b1;
    step();
    m_q = '0; m_ptr = 0;
    total++; exp_v = expect_out('0, 1'b0, 1'b0, 8'h00);
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_dropped got=%h want=%h", obs, exp_v); end
    RST = 1'b0; REQ = '0;
    step();
    total++; exp_v = expect_out('0, 1'b0, 1'b0, 8'h00);
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_after got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_random();
    int          w;
    logic        abort;
    logic [N-1:0] r;
    for (int it = 0; it < 300; it++) begin
      r     = N'($urandom_range(0, (1 << N) - 1));
      REQ   = r;
      CLR   = ($urandom_range(0, 7) == 0);
      WDATA = $urandom;
      if (CLR) begin
        step();
        m_q = '0;
        total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
        if (obs !== exp_v) begin bad++; $display("FAIL rnd_clr it=%0d got=%h want=%h", it, obs, exp_v); end
      end else if (r == '0) begin
        step();
        total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
        if (obs !== exp_v) begin bad++; $display("FAIL rnd_idle it=%0d got=%h want=%h", it, obs, exp_v); end
      end else begin
        w = rr_winner(r, m_ptr);
        step();
        total++; exp_v = expect_out(onehot(w), 1'b0, 1'b1, m_q);
        if (obs !== exp_v) begin bad++; $display("FAIL rnd_grant it=%0d got=%h want=%h", it, obs, exp_v); end
        abort  = ($urandom_range(0, 3) == 0);
        REQ    = N'($urandom_range(0, (1 << N) - 1));
        REQ[w] = ~abort;
        CLR    = 1'($urandom_range(0, 1));
        step();
        if (abort) begin
          total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
          if (obs !== exp_v) begin bad++; $display("FAIL rnd_abort it=%0d got=%h want=%h", it, obs, exp_v); end
        end else begin
          m_q = WDATA[w*W +: W]; m_ptr = (w + 1) % N;
          total++; exp_v = expect_out('0, 1'b1, 1'b1, m_q);
          if (obs !== exp_v) begin bad++; $display("FAIL rnd_ack it=%0d got=%h want=%h", it, obs, exp_v); end
          REQ    = N'($urandom_range(0, (1 << N) - 1));
          REQ[w] = 1'b0;
          CLR    = 1'($urandom_range(0, 1));
          step();
          total++; exp_v = expect_out('0, 1'b0, 1'b0, m_q);
          if (obs !== exp_v) begin bad++; $display("FAIL rnd_done it=%0d got=%h want=%h", it, obs, exp_v); end
        end
      end
    end
    CLR = 1'b0; REQ = '0;
  endtask

  initial begin
    RST = 1'b1; REQ = '0; CLR = 1'b0; WDATA = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_abort();
    test_clr_priority();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
